// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control, data and status bundle for the jk_reg_bank flip-flop bank.
interface jk_reg_bank_if #(parameter int WIDTH = 8);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             changed;
    logic             wrap;
    modport master (output en, mode, j, k, d, up, input q, changed, wrap);
    modport slave (input en, mode, j, k, d, up, output q, changed, wrap);
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH JK flip-flops with JK, LOAD, TOGGLE and up/down COUNT modes.
// Every mode is mapped onto per-bit J/K terms so a single JK update rule drives the bank.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic         clk,
    input logic         reset,
    jk_reg_bank_if.slave bus
);
    logic [WIDTH-1:0] tc, jj, kk, nq;
    logic             all1, all0, wrap_n;
    always_comb begin
        tc   = '0;
        all1 = 1'b1;
        all0 = 1'b1;
        // bit i toggles when every lower bit is one (up) or zero (down)
        for (int i = 0; i < WIDTH; i++) begin
            tc[i] = bus.up ? all1 : all0;
            all1  = all1 & bus.q[i];
            all0  = all0 & ~bus.q[i];
        end
        jj = bus.mode == 2'b00 ? bus.j : bus.mode == 2'b11 ? tc : bus.d;
        kk = bus.mode == 2'b00 ? bus.k : bus.mode == 2'b01 ? ~bus.d : bus.mode == 2'b10 ? bus.d : tc;
        nq = (jj & ~bus.q) | (~kk & bus.q);
        wrap_n = bus.mode == 2'b11 && (bus.up ? all1 : all0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.q       <= RESET_VAL;
            bus.changed <= 1'b0;
            bus.wrap    <= 1'b0;
        end else if (!bus.en) begin
            bus.changed <= 1'b0;
            bus.wrap    <= 1'b0;
        end else begin
            bus.q       <= nq;
            bus.changed <= nq != bus.q;
            bus.wrap    <= wrap_n;
        end
    end
endmodule
